// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame transmit scheduler.
package frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam int ETH_MAX_FRAME = 1518;
  localparam int DEFAULT_IFG   = 12;

endpackage

// File: rtl/rr_prio_arbiter.sv
// Combinational arbiter: the high-priority subset wins if non-empty, then the
// first member at or after the round-robin pointer is chosen.
module rr_prio_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] hi_i,
  input  logic [IW-1:0]      rr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  logic [NUM_SRC-1:0] set;
  logic [IW:0]        pos;
  logic               found;

  always_comb begin
    set     = (|(req_i & hi_i)) ? (req_i & hi_i) : req_i;
    valid_o = |set;
    idx_o   = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = {1'b0, rr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_SRC)) pos = pos - (IW+1)'(NUM_SRC);
      if (!found && set[pos[IW-1:0]]) begin
        idx_o = pos[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_tx_sched.sv
// Shares one MAC TX byte stream between several frame FIFOs, one whole frame
// at a time, with an enforced inter-frame gap and an over-length abort.
//
// state  | meaning
// IDLE   | arbitrate among sources holding a complete frame
// STREAM | pass granted FIFO head to the MAC until the EOD byte
// FLUSH  | frame hit MAX_LEN without EOD: discard up to the EOD byte
// GAP    | hold off IFG_CYCLES clocks before the next arbitration
module frame_tx_sched
  import frame_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int IFG_CYCLES = DEFAULT_IFG,
  parameter int MAX_LEN    = ETH_MAX_FRAME,
  parameter int LW         = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*NUM_SRC-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_eod,
  input  logic [NUM_SRC-1:0]         src_empty,
  input  logic [NUM_SRC-1:0]         src_frame,
  input  logic [NUM_SRC-1:0]         src_half,
  output logic [NUM_SRC-1:0]         src_re,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  output logic                       tx_last,
  output logic                       tx_err,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_SRC)-1:0] grant,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int GW = $clog2(IFG_CYCLES + 1);

  state_e          state_q;
  logic [IW-1:0]   grant_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   rr_d;
  logic [LW-1:0]   len_q;
  logic [GW-1:0]   gap_q;

  logic [7:0]      data_arr [NUM_SRC];
  logic [7:0]      head_data;
  logic            head_empty;
  logic            head_eod;
  logic            at_max;
  logic            in_stream;
  logic            in_flush;
  logic            take;
  logic            flush_rd;
  logic            arb_valid;
  logic [IW-1:0]   arb_idx;

  rr_prio_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_arb (
    .req_i   (src_frame & ~src_empty),
    .hi_i    (src_half),
    .rr_i    (rr_q),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) data_arr[i] = src_data[8*i +: 8];
  end

  // Stream outputs are gated by rst so nothing is read while reset is held.
  always_comb begin
    head_data  = data_arr[grant_q];
    head_empty = src_empty[grant_q];
    head_eod   = src_eod[grant_q];
    at_max     = (len_q == LW'(MAX_LEN - 1));
    in_stream  = (state_q == ST_STREAM) && !rst;
    in_flush   = (state_q == ST_FLUSH) && !rst;
    tx_valid   = in_stream && !head_empty;
    tx_data    = in_stream ? head_data : 8'h00;
    tx_last    = in_stream && (head_eod || at_max);
    tx_err     = in_stream && at_max && !head_eod;
    take       = tx_valid && tx_ready;
    flush_rd   = in_flush && !head_empty;
    src_re     = '0;
    if (take || flush_rd) src_re[grant_q] = 1'b1;
    rr_d       = (grant_q == IW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q <= arb_idx;
            len_q   <= '0;
            state_q <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (take) begin
            if (len_q != '1) len_q <= len_q + 1'b1;
            if (head_eod) begin
              rr_q    <= rr_d;
              gap_q   <= GW'(IFG_CYCLES - 1);
              state_q <= ST_GAP;
            end else if (at_max) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_rd && head_eod) begin
            rr_q    <= rr_d;
            gap_q   <= GW'(IFG_CYCLES - 1);
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_q <= ST_IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_sched.sv
// Directed bench for frame_tx_sched: FIFO models feed the DUT, and a
// frame-level model predicts arbitration order, byte stream, abort and gap.
module tb_frame_tx_sched;

  localparam int N       = 2;
  localparam int IFG     = 12;
  localparam int MAXL    = 1518;
  localparam int HALF_TH = 40;

  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_FLUSH = 2;
  localparam int M_GAP   = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [8*N-1:0] src_data;
  logic [N-1:0] src_eod, src_empty, src_frame, src_half, src_re;
  logic [7:0]   tx_data;
  logic         tx_valid, tx_last, tx_err, tx_ready;
  logic [$clog2(N)-1:0] grant;
  logic         busy;

  frame_tx_sched #(
    .NUM_SRC    (N),
    .IFG_CYCLES (IFG),
    .MAX_LEN    (MAXL),
    .LW         (11)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_data  (src_data),
    .src_eod   (src_eod),
    .src_empty (src_empty),
    .src_frame (src_frame),
    .src_half  (src_half),
    .src_re    (src_re),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_err    (tx_err),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [8:0] fifo_q [N][$];
  logic [8:0] exp_q  [N][$];
  int nfr  [N];
  int pops [N];
  logic [N-1:0] re_s;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int m_phase = M_IDLE;
  int rr_m = 0, exp_src = 0, cnt = 0, gapc = 0, prev_end = -1;
  int hs_total = 0, last_total = 0, err_total = 0, frames_done = 0;
  int order_log [$];
  int gap_log   [$];
  logic       hs, lastx, errx;
  logic [8:0] b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    logic [8:0] h;
    for (int i = 0; i < N; i++) begin
      h = (fifo_q[i].size() > 0) ? fifo_q[i][0] : 9'h000;
      src_empty[i]       = (fifo_q[i].size() == 0);
      src_data[8*i +: 8] = h[7:0];
      src_eod[i]         = h[8];
      src_frame[i]       = (nfr[i] > 0);
      src_half[i]        = (fifo_q[i].size() >= HALF_TH);
    end
  endtask

  task automatic push_frame(input int s, input int len, input int base);
    logic [8:0] w;
    for (int k = 0; k < len; k++) begin
      w = {(k == len - 1), 8'(base + k)};
      fifo_q[s].push_back(w);
      exp_q[s].push_back(w);
    end
    nfr[s]++;
    refresh();
  endtask

  function automatic int pick(input int rr);
    bit anyhi = 0;
    int r = -1;
    int j;
    for (int i = 0; i < N; i++)
      if (nfr[i] > 0 && fifo_q[i].size() > 0 && fifo_q[i].size() >= HALF_TH) anyhi = 1;
    for (int k = 0; k < N; k++) begin
      j = (rr + k) % N;
      if (r < 0 && nfr[j] > 0 && fifo_q[j].size() > 0 && (!anyhi || fifo_q[j].size() >= HALF_TH))
        r = j;
    end
    return r;
  endfunction

  task automatic end_frame();
    rr_m     = (exp_src + 1) % N;
    m_phase  = M_GAP;
    gapc     = IFG;
    prev_end = cyc;
    frames_done++;
  endtask

  // FIFO model: a read enable seen before the edge retires the head byte
  always @(posedge clk) begin
    logic [8:0] h;
    #1;
    for (int i = 0; i < N; i++) begin
      if (re_s[i] && fifo_q[i].size() > 0) begin
        h = fifo_q[i].pop_front();
        if (h[8]) nfr[i]--;
        pops[i]++;
      end
    end
    refresh();
  end

  always @(negedge clk) begin
    cyc++;
    re_s = src_re;
    if (rst) begin
      m_phase  = M_IDLE;
      rr_m     = 0;
      prev_end = -1;
    end else begin
      chk("re_onehot0", ($countones(src_re) <= 1), 1);
      chk("re_while_empty", src_re & src_empty, 0);
      hs = tx_valid && tx_ready;
      if (m_phase == M_GAP) begin
        chk("gap_valid", tx_valid, 0);
        chk("gap_re", src_re, 0);
        chk("gap_busy", busy, 1);
        gapc--;
        if (gapc == 0) m_phase = M_IDLE;
      end else if (m_phase == M_IDLE) begin
        if (tx_valid) begin
          exp_src = pick(rr_m);
          chk("arb_grant", grant, exp_src);
          if (exp_src < 0) exp_src = grant;
          order_log.push_back(exp_src);
          if (prev_end >= 0) gap_log.push_back(cyc - prev_end - 1);
          cnt = 0;
          m_phase = M_FRAME;
        end else begin
          chk("idle_re", src_re, 0);
        end
      end
      if (m_phase == M_FRAME) begin
        chk("stream_grant", grant, exp_src);
        chk("stream_busy", busy, 1);
        if (tx_valid) begin
          if (exp_q[exp_src].size() == 0) begin
            chk("extra_byte", 1, 0);
          end else begin
            b     = exp_q[exp_src][0];
            lastx = b[8] || (cnt + 1 == MAXL);
            errx  = !b[8] && (cnt + 1 == MAXL);
            chk("tx_data", tx_data, b[7:0]);
            chk("tx_last", tx_last, lastx);
            chk("tx_err", tx_err, errx);
            chk("stream_re", src_re, hs ? (64'd1 << exp_src) : 64'd0);
            if (hs) begin
              void'(exp_q[exp_src].pop_front());
              cnt++;
              hs_total++;
              if (tx_last) last_total++;
              if (tx_err) err_total++;
              if (b[8]) end_frame();
              else if (errx) begin
                while (exp_q[exp_src].size() > 0) begin
                  b = exp_q[exp_src].pop_front();
                  if (b[8]) break;
                end
                m_phase = M_FLUSH;
              end
            end
          end
        end else begin
          chk("stall_re", src_re, 0);
        end
      end else if (m_phase == M_FLUSH) begin
        chk("flush_valid", tx_valid, 0);
        chk("flush_re", src_re, src_empty[exp_src] ? 64'd0 : (64'd1 << exp_src));
        if (src_re[exp_src] && src_eod[exp_src]) begin
          chk("flush_len", fifo_q[exp_src].size() - 1, exp_q[exp_src].size());
          end_frame();
        end
      end
    end
  end

  task automatic clear_stats();
    hs_total = 0; last_total = 0; err_total = 0; frames_done = 0;
    for (int i = 0; i < N; i++) pops[i] = 0;
    order_log.delete();
    gap_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tx_ready = 1'b1;
  endtask

  task automatic wait_done(input int n, input int budget);
    int c = 0;
    while (!(frames_done >= n && m_phase == M_IDLE) && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (c >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: timeout after %0d cycles, frames %0d of %0d", c, frames_done, n);
    end
  endtask

  task automatic chk_order(input string nm, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_len"}, order_log.size(), n);
    for (int k = 0; k < n && k < order_log.size(); k++) chk(nm, order_log[k], e[k]);
  endtask

  initial begin
    int c;
    tx_ready = 1'b1;
    re_s     = '0;
    for (int i = 0; i < N; i++) begin nfr[i] = 0; pops[i] = 0; end
    refresh();

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_err", tx_err, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_src_re", src_re, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2 rst = 1'b0;

    // 64-byte frame followed by a short one from the same source
    clear_stats();
    push_frame(0, 64, 8'h10);
    push_frame(0, 5, 8'hA0);
    wait_done(2, 400);
    chk("t1_bytes", hs_total, 69);
    chk("t1_lasts", last_total, 2);
    chk("t1_errs", err_total, 0);
    chk_order("t1_order", 2, 0, 0, 0, 0);
    if (gap_log.size() > 0) chk("t1_gap", gap_log[0], IFG + 1);
    else chk("t1_gap_seen", gap_log.size(), 1);

    // plain round robin
    do_reset();
    clear_stats();
    push_frame(0, 8, 8'h20);
    push_frame(1, 8, 8'h40);
    push_frame(0, 8, 8'h60);
    push_frame(1, 8, 8'h80);
    wait_done(4, 600);
    chk_order("t2_order", 4, 0, 1, 0, 1);
    chk("t2_gaps", gap_log.size(), 3);
    foreach (gap_log[k]) chk("t2_gap", gap_log[k], IFG + 1);

    // half-full source goes first, then round robin resumes
    do_reset();
    clear_stats();
    push_frame(0, 10, 8'h00);
    push_frame(0, 10, 8'h0A);
    push_frame(1, 30, 8'h50);
    push_frame(1, 30, 8'h70);
    wait_done(4, 800);
    chk_order("t3_order", 4, 1, 0, 1, 0);
    chk("t3_bytes", hs_total, 80);

    // back-pressure toggling every clock
    do_reset();
    clear_stats();
    push_frame(0, 10, 8'hC0);
    c = 0;
    while (frames_done < 1 && c < 200) begin
      @(posedge clk); #2 tx_ready = ~tx_ready;
      c++;
    end
    tx_ready = 1'b1;
    wait_done(1, 100);
    chk("t4_pops", pops[0], 10);
    chk("t4_bytes", hs_total, 10);
    chk("t4_lasts", last_total, 1);

    // over-length frame: abort at MAX_LEN, flush the rest, next frame intact
    do_reset();
    clear_stats();
    push_frame(0, 1600, 8'h00);
    push_frame(0, 3, 8'h55);
    wait_done(2, 2500);
    chk("t5_bytes", hs_total, MAXL + 3);
    chk("t5_errs", err_total, 1);
    chk("t5_lasts", last_total, 2);
    chk("t5_pops", pops[0], 1603);
    chk_order("t5_order", 2, 0, 0, 0, 0);

    // reset in the middle of a frame
    do_reset();
    clear_stats();
    push_frame(0, 64, 8'h30);
    c = 0;
    while (hs_total < 20 && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    chk("t6_reach20", hs_total, 20);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_inrst_valid", tx_valid, 0);
    chk("t6_inrst_re", src_re, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); #1;
    chk("t6_valid", tx_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_re", src_re, 0);
    chk("t6_pops", pops[0], 20);
    wait_done(1, 300);
    chk("t6_bytes", hs_total, 64);
    chk("t6_pops_end", pops[0], 64);
    chk_order("t6_order", 2, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_tx_sched.md
Name: frame_tx_sched

Overview:
- Frame-granular scheduler that shares one MAC TX byte stream between NUM_SRC FRAME_FIFO read ports.
- Each FIFO read side (data, EOD, empty, frame_exist, half_flag) connects to this block, which drives that FIFO's `re`.
- The block picks a source holding a complete frame and drains it to the EOD byte, then inserts an inter-frame gap.
- Sources with `half_flag` asserted take priority; within a priority class, selection is round-robin.

Parameters:
- NUM_SRC, 2, number of FIFO sources (2..4).
- IFG_CYCLES, 12, idle clocks forced between frames (minimum 1).
- MAX_LEN, 1518, byte cap per frame; reaching it without EOD triggers an abort.
- LW, 11, length counter width; must satisfy 2**LW > MAX_LEN.

Ports:
- clk  in  1  single clock, shared with the FIFO read clocks.
- rst  in  1  synchronous, active-high reset.
- src_data  in  8*NUM_SRC  FIFO head byte per source; source i is in bits [8i+7:8i].
- src_eod  in  NUM_SRC  head byte is the last byte of its frame.
- src_empty  in  NUM_SRC  FIFO empty_flag.
- src_frame  in  NUM_SRC  FIFO frame_exist.
- src_half  in  NUM_SRC  FIFO half_flag.
- src_re  out  NUM_SRC  read enable per FIFO; one-hot or zero.
- tx_data  out  8  byte to the MAC.
- tx_valid  out  1  tx_data is valid.
- tx_last  out  1  final byte of the frame.
- tx_err  out  1  frame aborted; qualified by tx_valid & tx_last.
- tx_ready  in  1  MAC accepts a byte when tx_valid & tx_ready.
- grant  out  $clog2(NUM_SRC)  index of the current or last granted source.
- busy  out  1  state != IDLE.

Behaviour:
- **Reset** (rst=1 at a clk edge):
  - State IDLE; rr pointer 0; grant 0; len 0; gap counter 0.
  - All outputs 0. src_re is 0 during reset.
- **FIFO read model:**
  - The head byte is valid whenever src_empty[i]=0.
  - Pulsing src_re[i] for one clock advances to the next byte, which is visible the following clock.
- **States:** IDLE, STREAM, FLUSH, GAP.
- **IDLE:**
  - Candidate set: src_frame & ~src_empty.
  - If any candidate has src_half=1, restrict the set to those candidates.
  - Choose the first set member at or after rr (modulo NUM_SRC), register it as grant, clear len, go to STREAM. Arbitration takes one clock.
  - No byte is read in IDLE.
- **STREAM:**
  - tx_valid = ~src_empty[grant]; tx_data = src_data[grant]; tx_last = src_eod[grant]; tx_err = 0. These are combinational from the FIFO head.
  - src_re[grant] = tx_valid & tx_ready. The MAC handshake is passed straight through.
  - On each accepted byte, len increments.
  - If the accepted byte has eod=1: rr = grant+1, go to GAP.
  - If the accepted byte is byte number MAX_LEN and has eod=0:
    - That byte is presented with tx_last=1 and tx_err=1.
    - Go to FLUSH.
  - If src_empty goes high mid-frame (underrun), tx_valid drops and the block waits in STREAM. There is no timeout.
  - If the grant loses its src_half priority mid-frame, nothing changes; the current frame always completes.
- **FLUSH:**
  - tx_valid = 0.
  - src_re[grant] = ~src_empty[grant], discarding bytes without involving the MAC.
  - When the discarded byte has eod=1: rr = grant+1, go to GAP.
- **GAP:**
  - Hold tx_valid = 0 for IFG_CYCLES clocks, then return to IDLE.
  - The gap also covers the one-clock frame_exist update latency after an EOD read.
- **Counter widths:**
  - len is LW bits wide and saturates; it cannot wrap because abort occurs at MAX_LEN.
  - The gap counter is $clog2(IFG_CYCLES+1) bits wide.
- **Simultaneous events:**
  - A byte that is both EOD and byte number MAX_LEN is a normal last byte: tx_err=0, go to GAP.
  - Requests arriving during STREAM, FLUSH or GAP are sampled only in IDLE.
- **Mid-operation reset:** returns to IDLE immediately. Any partially drained frame remains in its FIFO; resynchronising it is the FIFO owner's responsibility.
- **Invariants (asserted in simulation):**
  - At most one src_re bit is high.
  - src_re[i] is never high while src_empty[i]=1.
  - tx_valid is never high outside STREAM.

Decomposition:
- Shared package (frame_pkg):
  - State encoding constants ST_IDLE, ST_STREAM, ST_FLUSH, ST_GAP.
  - ETH_MAX_FRAME = 1518.
  - Default IFG = 12.
- One sub-module, rr_prio_arbiter:
  - Combinational; inputs req[NUM_SRC], hi[NUM_SRC] and rr pointer.
  - Outputs a valid flag and the granted index.
- This top module keeps the FSM, counters and mux.

Test Plan:
1. Single source 0 holds a 64-byte frame (eod on byte 64), tx_ready=1.
   - grant=0; 64 consecutive tx_valid cycles with tx_last only on byte 64; tx_err=0.
   - Then 12 idle clocks before any next frame.
2. Both sources hold frames, both half=0, reset state (rr=0).
   - Order is src0, src1, src0, src1.
   - rr advances after each EOD.
3. Both sources hold frames, src1 half=1.
   - src1 is served first even with rr=0.
   - After src1's half clears, round-robin resumes.
4. tx_ready toggles 1/0 every clock during a 10-byte frame.
   - Exactly 10 src_re pulses.
   - tx_data sequence matches FIFO content.
   - No duplicated or skipped bytes.
5. Source 0 frame of 1600 bytes with no EOD until byte 1600, MAX_LEN=1518.
   - Byte 1518 is output with tx_last=1, tx_err=1.
   - 82 bytes are flushed with tx_valid=0, then GAP.
6. rst asserted mid-STREAM at byte 20.
   - Next clock: tx_valid=0, busy=0, src_re=0.
   - After release, a new arbitration occurs.
